// File: rtl/sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding and sweep geometry.
package sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned HOLD_W      = 8;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

endpackage

// File: rtl/truth_table_sweeper_hold_counter.sv
// Modulo-HOLD_CYCLES dwell counter; wrap_o marks the capture cycle of each vector.
module hold_counter
  import sweep_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic wrap_o
);

  localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap_o = en_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (clr_i || wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 8 {g,v,y} vectors into a 3-in/1-out unit, captures j into a truth
// table and compares it with the table latched at start.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       j_in,
  output logic       g_out,
  output logic       v_out,
  output logic       y_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       pass
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       shadow_q, shadow_d;
  logic [7:0]       exp_q, exp_d;
  logic [7:0]       table_q, table_d;
  logic             pass_q, pass_d;
  logic [2:0]       stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             capture;

  hold_counter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (state_q != ST_DRIVE),
    .en_i  (state_q == ST_DRIVE),
    .wrap_o(capture)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    exp_d    = exp_q;
    table_d  = table_q;
    pass_d   = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_DRIVE;
          exp_d    = expected;
          idx_d    = '0;
          shadow_d = '0;
        end
      end
      ST_DRIVE: begin
        if (capture) begin
          shadow_d[idx_q] = j_in;
          if (idx_q == LAST_IDX) begin
            // Publish on the edge entering DONE so table/pass are valid alongside done.
            state_d = ST_DONE;
            table_d = shadow_d;
            pass_d  = (shadow_d == exp_q);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from next-state values, so they line up with the state.
    stim_d = (state_d == ST_DRIVE) ? idx_d : 3'd0;
    busy_d = (state_d == ST_DRIVE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      exp_q    <= '0;
      table_q  <= '0;
      pass_q   <= 1'b0;
      stim_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      exp_q    <= exp_d;
      table_q  <= table_d;
      pass_q   <= pass_d;
      stim_q   <= stim_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign g_out     = stim_q[2];
  assign v_out     = stim_q[1];
  assign y_out     = stim_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (H=10 and H=1) each driving a modelled unit.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] start_v;
  logic [7:0] exp_v [2];
  logic [1:0] jv, g_v, v_v, y_v, busy_v, done_v, pass_v;
  logic [7:0] tab_v [2];
  int         kind_v [2];
  logic [7:0] rt_v [2];
  int         HV [2] = '{10, 1};
  logic [7:0] mtab [2];
  logic       mpass [2];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  truth_table_sweeper #(.HOLD_CYCLES(10)) u_h10 (
    .clock(clk), .reset(reset), .start(start_v[0]), .expected(exp_v[0]), .j_in(jv[0]),
    .g_out(g_v[0]), .v_out(v_v[0]), .y_out(y_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .table_out(tab_v[0]), .pass(pass_v[0])
  );

  truth_table_sweeper #(.HOLD_CYCLES(1)) u_h1 (
    .clock(clk), .reset(reset), .start(start_v[1]), .expected(exp_v[1]), .j_in(jv[1]),
    .g_out(g_v[1]), .v_out(v_v[1]), .y_out(y_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .table_out(tab_v[1]), .pass(pass_v[1])
  );

  // Unit kinds: 0=(g&v)|y, 1=g^v^y, 2=const0, 3=const1, other=random lookup table
  function automatic logic unit_eval(input int kind, input logic [2:0] x, input logic [7:0] rt);
    case (kind)
      0: return (x[2] & x[1]) | x[0];
      1: return ^x;
      2: return 1'b0;
      3: return 1'b1;
      default: return rt[x];
    endcase
  endfunction

  assign jv[0] = unit_eval(kind_v[0], {g_v[0], v_v[0], y_v[0]}, rt_v[0]);
  assign jv[1] = unit_eval(kind_v[1], {g_v[1], v_v[1], y_v[1]}, rt_v[1]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [12:0] outs(input int d);
    return {busy_v[d], done_v[d], g_v[d], v_v[d], y_v[d], pass_v[d], tab_v[d]};
  endfunction

  task automatic run_sweep(input int d, input int kind, input logic [7:0] e,
                           input logic [7:0] want_tab, input logic want_pass,
                           input int poke1, input int poke2, input int rst_at);
    int h, last, errs;
    bit aborted;
    logic [2:0] exp_stim;
    h = HV[d];
    last = 8 * h + 1;
    errs = 0;
    aborted = 0;
    @(negedge clk);
    kind_v[d] = kind;
    exp_v[d] = e;
    start_v[d] = 1'b1;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    exp_v[d] = ~e;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (rst_at != 0 && c == rst_at + 1) begin
        reset = 1'b0;
        check("reset_mid_sweep_outputs", 32'(outs(d)), 32'd0);
        mtab[0] = 8'h00; mtab[1] = 8'h00;
        mpass[0] = 1'b0; mpass[1] = 1'b0;
        aborted = 1;
        break;
      end
      exp_stim = (c <= 8 * h) ? 3'((c - 1) / h) : 3'd0;
      if ({g_v[d], v_v[d], y_v[d]} != exp_stim) errs++;
      if (busy_v[d] != (c <= 8 * h)) errs++;
      if (done_v[d] != (c == last)) errs++;
      if (c < last && (tab_v[d] != mtab[d] || pass_v[d] != mpass[d])) errs++;
      start_v[d] = (c == poke1) || (c == poke2);
      if (rst_at != 0 && c == rst_at) reset = 1'b1;
    end
    check("sweep_sequence", 32'(errs), 32'd0);
    if (!aborted) begin
      check("table_out", 32'(tab_v[d]), 32'(want_tab));
      check("pass", 32'(pass_v[d]), 32'(want_pass));
      mtab[d] = want_tab;
      mpass[d] = want_pass;
    end
    errs = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      start_v[d] = 1'b0;
      if (busy_v[d] || done_v[d] || tab_v[d] != mtab[d] || pass_v[d] != mpass[d]) errs++;
    end
    check("idle_hold", 32'(errs), 32'd0);
  endtask

  typedef struct {
    int         dut;
    int         kind;
    logic [7:0] exp;
    logic [7:0] want_tab;
    logic       want_pass;
  } vec_t;

  initial begin
    vec_t vecs [6];
    int   dq [$];
    int   d;
    logic [7:0] e, want;

    vecs[0] = '{0, 0, 8'hEA, 8'hEA, 1'b1};
    vecs[1] = '{0, 0, 8'hEB, 8'hEA, 1'b0};
    vecs[2] = '{1, 1, 8'h96, 8'h96, 1'b1};
    vecs[3] = '{0, 2, 8'h00, 8'h00, 1'b1};
    vecs[4] = '{0, 3, 8'hFF, 8'hFF, 1'b1};
    vecs[5] = '{1, 0, 8'h00, 8'hEA, 1'b0};

    reset = 1'b1;
    start_v = 2'b00;
    exp_v[0] = 8'h00; exp_v[1] = 8'h00;
    kind_v[0] = 0; kind_v[1] = 0;
    rt_v[0] = 8'h00; rt_v[1] = 8'h00;
    mtab[0] = 8'h00; mtab[1] = 8'h00;
    mpass[0] = 1'b0; mpass[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state_h10", 32'(outs(0)), 32'd0);
    check("reset_state_h1", 32'(outs(1)), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run_sweep(vecs[i].dut, vecs[i].kind, vecs[i].exp, vecs[i].want_tab, vecs[i].want_pass, 0, 0, 0);

    // start pulses during DRIVE and in the DONE cycle are ignored
    run_sweep(0, 0, 8'hEA, 8'hEA, 1'b1, 20, 81, 0);

    // reset mid-sweep, then a fresh sweep completes
    run_sweep(0, 1, 8'h96, 8'h96, 1'b1, 0, 0, 35);
    run_sweep(0, 1, 8'h96, 8'h96, 1'b1, 0, 0, 0);

    // reset and start in the same cycle: reset wins
    @(negedge clk);
    reset = 1'b1;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start_v[0] = 1'b0;
    @(posedge clk);
    #1;
    check("reset_beats_start", 32'({busy_v[0], done_v[0], tab_v[0]}), 32'd0);
    mtab[0] = 8'h00; mtab[1] = 8'h00;
    mpass[0] = 1'b0; mpass[1] = 1'b0;

    // start held high: back-to-back sweeps
    @(negedge clk);
    kind_v[0] = 0;
    exp_v[0] = 8'hEA;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 170; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (done_v[0]) dq.push_back(c);
      if (c == 163) start_v[0] = 1'b0;
    end
    check("b2b_done_count", 32'(dq.size()), 32'd2);
    if (dq.size() >= 2) begin
      check("b2b_done_first", 32'(dq[0]), 32'd81);
      check("b2b_done_second", 32'(dq[1]), 32'd163);
    end
    check("b2b_table", 32'({pass_v[0], tab_v[0]}), 32'h1EA);
    mtab[0] = 8'hEA;
    mpass[0] = 1'b1;

    // randomized unit functions and expected tables
    for (int i = 0; i < 6; i++) begin
      d = int'($urandom_range(0, 1));
      rt_v[d] = 8'($urandom);
      for (int x = 0; x < 8; x++) want[x] = unit_eval(4, 3'(x), rt_v[d]);
      e = ($urandom_range(0, 1) == 1) ? want : 8'($urandom);
      run_sweep(d, 4, e, want, (want == e), 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus-and-capture stage that wraps a 3-input, 1-output combinational unit such as `blackbox`. It drives `g`, `v` and `y` through all 8 input combinations, holding each one for a programmable number of cycles. On the last cycle of each hold it samples the unit's `j` output, assembles an 8-bit truth table, and compares it against an expected table captured at `start`. It sits directly upstream (stimulus) and downstream (response) of the combinational unit in the lab datapath.

## Interface
- `HOLD_CYCLES`, default 10: cycles each input vector is held; legal range 1..255.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a sweep when sampled high in IDLE.
- `expected`  in  8  reference truth table; sampled on the accepted `start` cycle.
- `j_in`  in  1  output of the combinational unit under sweep.
- `g_out`, `v_out`, `y_out`  out  1 each  registered stimulus to the unit.
- `busy`  out  1  high in DRIVE.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `table_out`  out  8  captured table; bit `i` is `j` for input `{g,v,y} == i`.
- `pass`  out  1  `table_out == expected latch`; valid from `done` onward.

## Operation
- Reset values: state IDLE; `g_out`, `v_out`, `y_out` = 0; `busy` = 0; `done` = 0; `table_out` = 8'h00; `pass` = 0; index, hold counter, shadow table and expected latch all 0.
- States:
  - IDLE → DRIVE when `start` = 1. On entry to DRIVE: latch `expected`, set index = 0, hold = 0, clear the shadow table.
  - DRIVE: `{g_out,v_out,y_out}` = index, with `g` as MSB. Hold increments each cycle.
  - When hold == `HOLD_CYCLES`-1 (the capture cycle):
    - shadow[index] ← `j_in`;
    - hold ← 0;
    - index ← index+1, or DRIVE → DONE if index == 7.
  - DONE (exactly one cycle):
    - `done` = 1;
    - `table_out` ← shadow, published atomically;
    - `pass` ← (shadow == expected latch).
    - Then → IDLE.
  - Stimulus outputs return to 0 in DONE/IDLE.
- Boundary rules:
  - `start` while in DRIVE or DONE is ignored. No queueing.
  - `start` held high continuously: a new sweep begins on the first IDLE cycle after DONE.
  - `table_out` and `pass` hold their values until the next DONE or `reset`. They are not cleared by `start`.
  - The index is 3 bits. Completion is detected at index == 7 on the capture cycle, never by wrap to 0.
  - `HOLD_CYCLES` = 1: every DRIVE cycle is a capture cycle.
  - `reset` mid-sweep: all registers return to reset values on the next edge. The partial table is discarded, and no `done` pulse is produced.
  - `reset` and `start` high in the same cycle: `reset` wins.

## Timing
- `start` accepted at edge N. Vector 0 appears on the outputs after edge N+1.
- Vector k is driven for cycles N+1+k·H … N+(k+1)·H, where H = `HOLD_CYCLES`. Capture occurs in the last of those cycles.
- `j_in` is assumed combinationally settled within that cycle. A registered unit requires H ≥ 2.
- `done` is high in cycle N+8·H+1. `table_out` and `pass` become valid on the same edge.
- The earliest next accepted `start` is at cycle N+8·H+2.
- Total sweep latency from `start` to `done` is 8·H+1 cycles.

## Structure
- Shared package `sweep_pkg` holds:
  - the state encoding (IDLE=2'd0, DRIVE=2'd1, DONE=2'd2);
  - `NUM_VECTORS` = 8;
  - the index width of 3.
- One natural sub-module, `hold_counter`: a parameterised modulo-`HOLD_CYCLES` counter with a synchronous clear and a `wrap` (capture) output.
- The FSM, index register, shadow table and comparator stay in the top module.

## Test plan
- Stand-in unit j = (g&v)|y, H = 10, `start` with `expected` = 8'hEA.
  - `done` at cycle N+81.
  - `table_out` = 8'hEA, `pass` = 1.
  - Stimulus sequence 000, 001, …, 111, each held 10 cycles.
- Same unit, `expected` = 8'hEB → `table_out` = 8'hEA, `pass` = 0.
- H = 1, unit j = g^v^y → `done` at N+9, `table_out` = 8'h96.
- Assert `reset` at cycle N+35 of a sweep.
  - Next cycle shows all outputs = 0 and state IDLE.
  - No `done` pulse.
  - A fresh `start` completes normally.
- `start` pulsed again at N+20 and N+81.
  - Both are ignored.
  - Exactly one `done` pulse.
  - `start` held continuously produces back-to-back sweeps with `done` at N+81 and N+163.
- Constant-0 unit then constant-1 unit in successive sweeps → `table_out` 8'h00 then 8'hFF. The value holds between the two sweeps.
